ad1_responder: RTL
==================

# ad1_responder

Synthesizable responder side of the PmodAD1 serial link: emulates the two AD7476A converters that `AD1_Controller` reads. It watches the controller's chip-select and serial clock, oversampled in the system clock domain, and drives `aDATA1`/`aDATA2` with 16-bit frames: 4 leading zeros, then a 12-bit sample, MSB first. It is used as a loopback target in hardware and as the stimulus source in controller benches, replacing hand-timed `aDATA` waveforms.

## Interface
- `DATA_W`, default 12: sample width per channel.
- `LEAD_W`, default 4: leading zero bits per frame. Frame length is `LEAD_W+DATA_W` = 16.
- `SYNC_STAGES`, default 2: synchronizer depth on `CS` and `SCLK`, minimum 2.
- `SCLKI`, in, 1: system clock. All logic is on its rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `CS`, in, 1: controller chip-select, active low, asynchronous to `SCLKI`.
- `SCLK`, in, 1: controller serial clock (the controller's `SCLKO`), idle high, asynchronous.
- `SAMPLE1`, in, `DATA_W`: channel 1 value to transmit.
- `SAMPLE2`, in, `DATA_W`: channel 2 value to transmit.
- `aDATA1`, out, 1: serial data, channel 1.
- `aDATA2`, out, 1: serial data, channel 2.
- `BUSY`, out, 1: high while a frame is in progress (states SHIFT and QUIET).
- `DONE`, out, 1: one-cycle pulse when all 16 bits have been shifted.
- `ABORT`, out, 1: one-cycle pulse when `CS` rises before the 16th falling edge of `SCLK`.

## Operation
- `CS` and `SCLK` each pass through `SYNC_STAGES` flops, then an edge detector. `cs_fall`, `cs_rise` and `sclk_fall` are one-cycle strobes.
- States: IDLE, SHIFT, QUIET.
- **IDLE:** `aDATA*`=0, `BUSY`=0.
  - On `cs_fall`, load each shift register with `{LEAD_W'b0, SAMPLEn}`, clear `bit_cnt`, and go to SHIFT.
  - Bit 15, a zero, is presented on the output immediately.
- **SHIFT:** each `sclk_fall` shifts left by one and increments `bit_cnt`. `aDATAn` always equals `shiftn[15]`.
  - On the `sclk_fall` that brings `bit_cnt` to 16: pulse `DONE`, force `aDATA*`=0, and go to QUIET.
- **QUIET:** `aDATA*`=0. Further `sclk_fall` strobes are ignored. On `cs_rise`, go to IDLE.
- **`cs_rise` in SHIFT:** go to IDLE, force `aDATA*`=0, pulse `ABORT`, no `DONE`.
- **Simultaneous events:**
  - `cs_rise` with `sclk_fall` in the same cycle: `cs_rise` wins and the shift does not happen.
  - `cs_fall` with `sclk_fall` in the same cycle: load only, the edge is discarded.
- **Sample capture:** samples are captured only on the `cs_fall` cycle. Changes to `SAMPLEn` mid-frame do not affect the frame in flight.
- **Reset:**
  - State IDLE; `aDATA1`=`aDATA2`=`BUSY`=`DONE`=`ABORT`=0; `bit_cnt`=0; shift registers 0.
  - Synchronizer flops reset to 1 (the idle level of `CS` and `SCLK`), so no false edge follows reset.
  - `RST` mid-frame abandons the frame without pulsing `ABORT`.

## Timing
- Output latency is `SYNC_STAGES`+1 `SCLKI` cycles from a pin edge of `CS`/`SCLK` to the change on `aDATA*`; with defaults this is 3 cycles.
- The `SCLK` period must be at least `2*(SYNC_STAGES+2)` `SCLKI` cycles, so that data is stable before the controller's next rising sample edge. This is 8 cycles with defaults.
- `DONE` and `ABORT` are registered and asserted in the cycle after the triggering strobe.
- `BUSY` rises the cycle after `cs_fall` and falls the cycle after `cs_rise`.

## Configuration
- **`AD1_RESP_TESTPATTERN_EN` defined:** `SAMPLE1`/`SAMPLE2` are ignored.
  - An internal `DATA_W`-bit counter, reset to 0, increments by 1 on every `DONE` and wraps from 0xFFF to 0.
  - Channel 1 sends the count; channel 2 sends its bitwise inverse.
  - Aborted frames do not advance the counter.
- **Undefined:** samples come from the ports and no counter is built.

## Structure
- **Package `ad1_pkg`:**
  - State enum: IDLE, SHIFT, QUIET.
  - Constants `AD1_LEAD_W`=4, `AD1_DATA_W`=12, `AD1_FRAME_W`=16.
  - `bit_cnt` width is `$clog2(AD1_FRAME_W+1)`.
- **Sub-module `ad1_edge_sync`:** parameterized synchronizer plus rise/fall detector with a reset value input. It is instantiated twice, once for `CS` and once for `SCLK`.

## Test plan
- **Full frame:** `SAMPLE1`=0xA5C, `SAMPLE2`=0x3F0; `SCLK` period 20 `SCLKI` cycles; `CS` low for 16 `SCLK` periods.
  - Bits captured on `SCLK` rising edges are 0x0A5C and 0x03F0.
  - `DONE` pulses exactly once; `ABORT` stays 0.
- **Abort after 7 falling edges:** `CS` rises.
  - `ABORT` pulses once; `aDATA*`=0 within 3 cycles; no `DONE`.
  - The next frame then returns the correct full word.
- **Extra clocks:** 20 falling edges while `CS` is low.
  - Bits 17–20 read as 0; `DONE` pulses once, at edge 16.
- **Mid-frame sample change:** `SAMPLE1` changes from 0x000 to 0xFFF after edge 5.
  - The frame still reads 0x0000; the next frame reads 0x0FFF.
- **Reset mid-frame:** `RST` asserted for 1 cycle at edge 8.
  - Outputs are 0 the next cycle; no `ABORT`; no spurious edge after release.
- **With `AD1_RESP_TESTPATTERN_EN`:** 3 full frames.
  - Channel 1 reads 0x000, 0x001, 0x002; channel 2 reads 0xFFF, 0xFFE, 0xFFD.
  - Preloading the counter to 0xFFF gives 0x000 on the following frame.

Source files
------------

// File: rtl/ad1_pkg.sv
// Purpose: shared types and constants for the PmodAD1 responder (AD7476A emulation).
// Latency: n/a (declarations only).
// Backpressure: n/a; the serial link has no flow control, the controller owns all timing.
//
// Contents:
//   ad1_state_e  - responder frame state (IDLE, SHIFT, QUIET)
//   AD1_LEAD_W   - leading zero bits per frame
//   AD1_DATA_W   - sample bits per frame
//   AD1_FRAME_W  - total frame length in bits
//   AD1_CNT_W    - width of the bit counter (must hold the value AD1_FRAME_W)
//   ad1_frame()  - builds the shift-register load word from a sample
package ad1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        QUIET = 2'd2
    } ad1_state_e;

    localparam int AD1_LEAD_W  = 4;
    localparam int AD1_DATA_W  = 12;
    localparam int AD1_FRAME_W = AD1_LEAD_W + AD1_DATA_W;
    localparam int AD1_CNT_W   = $clog2(AD1_FRAME_W + 1);

    // Frame word for the default geometry: leading zeros, then the sample MSB first.
    function automatic logic [AD1_FRAME_W-1:0] ad1_frame(input logic [AD1_DATA_W-1:0] sample);
        return {{AD1_LEAD_W{1'b0}}, sample};
    endfunction

endpackage

// File: rtl/ad1_edge_sync.sv
// Purpose: multi-flop synchronizer for an asynchronous level, plus rise/fall strobes.
// Latency: a pin edge produces a one-cycle strobe STAGES cycles later (combinational off the last stage).
// Backpressure: none; strobes are single-cycle and must be consumed in the cycle they appear.
//
// Ports:
//   clk_i      - sampling clock
//   rst_i      - synchronous active-high reset
//   rst_val_i  - level loaded into every flop on reset (use the input's idle level)
//   d_i        - asynchronous input
//   rise_o     - one-cycle strobe on a synchronized 0->1 transition
//   fall_o     - one-cycle strobe on a synchronized 1->0 transition
module ad1_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rst_val_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Resetting every flop to the idle level means the detector sees no
    // transition after reset unless the pin really sits at the other level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{rst_val_i}};
            prev_q <= rst_val_i;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/ad1_responder.sv
// Purpose: emulates the two AD7476A converters of a PmodAD1 (serial responder for AD1_Controller).
// Latency: SYNC_STAGES+1 SCLKI cycles from a CS/SCLK pin edge to the aDATA change (3 with defaults).
// Backpressure: none; the controller paces the frame, SCLK period must be >= 2*(SYNC_STAGES+2) SCLKI cycles.
//
// Ports:
//   SCLKI            - system clock, all logic on its rising edge
//   RST              - synchronous active-high reset
//   CS               - controller chip-select, active low, asynchronous
//   SCLK             - controller serial clock, idle high, asynchronous
//   SAMPLE1/SAMPLE2  - channel samples, captured on the CS falling edge
//   aDATA1/aDATA2    - serial data out, LEAD_W zeros then DATA_W sample bits, MSB first
//   BUSY             - frame in progress (SHIFT or QUIET)
//   DONE             - one-cycle pulse after the last bit has been shifted
//   ABORT            - one-cycle pulse when CS rises before the last SCLK falling edge
//
// Build option: define AD1_RESP_TESTPATTERN_EN to ignore SAMPLE1/SAMPLE2 and send an
// internal counter (channel 1) and its inverse (channel 2); the counter advances on DONE.
module ad1_responder
    import ad1_pkg::*;
#(
    parameter int DATA_W      = AD1_DATA_W,
    parameter int LEAD_W      = AD1_LEAD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              SCLKI,
    input  logic              RST,
    input  logic              CS,
    input  logic              SCLK,
    input  logic [DATA_W-1:0] SAMPLE1,
    input  logic [DATA_W-1:0] SAMPLE2,
    output logic              aDATA1,
    output logic              aDATA2,
    output logic              BUSY,
    output logic              DONE,
    output logic              ABORT
);

    localparam int FRAME_W = LEAD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    // ------------------------------------------------------------------
    // Input synchronizers and edge strobes
    // ------------------------------------------------------------------
    logic cs_rise;
    logic cs_fall;
    logic sclk_fall;
    logic sclk_rise_unused;

    ad1_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i     (SCLKI),
        .rst_i     (RST),
        .rst_val_i (1'b1),
        .d_i       (CS),
        .rise_o    (cs_rise),
        .fall_o    (cs_fall)
    );

    ad1_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_i     (SCLKI),
        .rst_i     (RST),
        .rst_val_i (1'b1),
        .d_i       (SCLK),
        .rise_o    (sclk_rise_unused),
        .fall_o    (sclk_fall)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    ad1_state_e         state_q, state_d;
    logic [FRAME_W-1:0] shift1_q, shift1_d;
    logic [FRAME_W-1:0] shift2_q, shift2_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;

    logic [DATA_W-1:0]  smp1;
    logic [DATA_W-1:0]  smp2;
    logic               last_bit;

    // The falling edge that completes the frame is the one seen while the
    // counter still holds FRAME_W-1.
    assign last_bit = (bit_cnt_q == CNT_W'(FRAME_W - 1));

    // ------------------------------------------------------------------
    // Sample source
    // ------------------------------------------------------------------
`ifdef AD1_RESP_TESTPATTERN_EN
    logic [DATA_W-1:0] pat_q, pat_d;
    logic              unused_samples;

    assign unused_samples = ^{SAMPLE1, SAMPLE2};

    // Advances only on a completed frame; aborted frames repeat the value.
    assign pat_d = done_d ? pat_q + DATA_W'(1) : pat_q;

    always_ff @(posedge SCLKI) begin
        if (RST) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign smp1 = pat_q;
    assign smp2 = ~pat_q;
`else
    assign smp1 = SAMPLE1;
    assign smp2 = SAMPLE2;
`endif

    // ------------------------------------------------------------------
    // FSM process 1: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge SCLKI) begin
        if (RST) begin
            state_q   <= IDLE;
            shift1_q  <= '0;
            shift2_q  <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift1_q  <= shift1_d;
            shift2_q  <= shift2_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // CS release has priority over a coincident SCLK edge.
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sclk_fall && last_bit) begin
                    state_d = QUIET;
                end
            end
            QUIET: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: load, shift, count, event pulses
    // ------------------------------------------------------------------
    always_comb begin
        shift1_d  = shift1_q;
        shift2_d  = shift2_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // A SCLK edge coincident with the CS fall is dropped: the
                // load must present the first leading zero for a full period.
                if (cs_fall) begin
                    shift1_d  = {{LEAD_W{1'b0}}, smp1};
                    shift2_d  = {{LEAD_W{1'b0}}, smp2};
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                end else if (sclk_fall) begin
                    shift1_d  = {shift1_q[FRAME_W-2:0], 1'b0};
                    shift2_d  = {shift2_q[FRAME_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    done_d    = last_bit;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        BUSY   = (state_q != IDLE);
        // Data lines are only driven from the shifters while shifting, so
        // both abort and completion force them low on the state change.
        aDATA1 = (state_q == SHIFT) & shift1_q[FRAME_W-1];
        aDATA2 = (state_q == SHIFT) & shift2_q[FRAME_W-1];
        DONE   = done_q;
        ABORT  = abort_q;
    end

endmodule
